// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller for the shared FP add and multiply pipelines.
// Tracks register hazards, FMADD second-phase add slots and the single writeback port.
module fpu_issue_ctrl #(
   parameter int ADD_LAT = 3,
   parameter int MUL_LAT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [4:0] req_rd,
   input  logic [4:0] req_rs1,
   input  logic [4:0] req_rs2,
   input  logic [4:0] req_rs3,
   output logic       add_issue,
   output logic       add_sub,
   output logic       add_src_sel,
   output logic [4:0] add_rs3,
   output logic       mul_issue,
   output logic       wb_valid,
   output logic [4:0] wb_rd,
   output logic       wb_sel,
   output logic       busy
);

   localparam int WB_LEN  = ADD_LAT + MUL_LAT + 1;
   localparam int P2_LEN  = MUL_LAT + 1;
   localparam int FMA_LAT = MUL_LAT + ADD_LAT;

   localparam logic [1:0] OP_FADD  = 2'd0;
   localparam logic [1:0] OP_FMUL  = 2'd1;
   localparam logic [1:0] OP_FMADD = 2'd2;
   localparam logic [1:0] OP_FSUB  = 2'd3;

   logic [31:0]             pending_r;
   logic [31:0]             pending_n_s;
   logic [WB_LEN-1:0]       wb_v_r;
   logic [WB_LEN-1:0]       wb_v_n_s;
   logic [WB_LEN-1:0][4:0]  wb_rd_r;
   logic [WB_LEN-1:0][4:0]  wb_rd_n_s;
   logic [WB_LEN-1:0]       wb_sel_r;
   logic [WB_LEN-1:0]       wb_sel_n_s;
   logic [P2_LEN-1:0]       p2_v_r;
   logic [P2_LEN-1:0]       p2_v_n_s;
   logic [P2_LEN-1:0][4:0]  p2_rs3_r;
   logic [P2_LEN-1:0][4:0]  p2_rs3_n_s;

   logic       is_add_op_s;
   logic       is_mul_op_s;
   logic       is_fma_s;
   logic       slot_busy_s;
   logic       raw_s;
   logic       waw_s;
   logic       port_s;
   logic       accept_s;
   logic       phase2_s;
   logic       wb_now_s;
   logic [31:0] set_mask_s;
   logic [31:0] clr_mask_s;

   // Decode the request and look up the writeback slot at its completion distance
   always_comb begin
      is_add_op_s = 1'b0;
      is_mul_op_s = 1'b0;
      is_fma_s    = 1'b0;
      slot_busy_s = 1'b0;
      case (req_op)
         OP_FADD, OP_FSUB: begin
            is_add_op_s = 1'b1;
            slot_busy_s = wb_v_r[ADD_LAT];
         end
         OP_FMUL: begin
            is_mul_op_s = 1'b1;
            slot_busy_s = wb_v_r[MUL_LAT];
         end
         OP_FMADD: begin
            is_mul_op_s = 1'b1;
            is_fma_s    = 1'b1;
            slot_busy_s = wb_v_r[FMA_LAT];
         end
         default: begin
            is_add_op_s = 1'b0;
            is_mul_op_s = 1'b0;
            is_fma_s    = 1'b0;
            slot_busy_s = 1'b1;
         end
      endcase
   end

   // Hazards use registered state only; a register cleared this cycle is usable next cycle
   always_comb begin
      raw_s     = pending_r[req_rs1] | pending_r[req_rs2] | (is_fma_s & pending_r[req_rs3]);
      waw_s     = pending_r[req_rd];
      port_s    = is_add_op_s & p2_v_r[0];
      req_ready = ~rst & ~raw_s & ~waw_s & ~slot_busy_s & ~port_s;
      accept_s  = req_valid & req_ready;
   end

   // Pipeline steering and writeback outputs; everything is forced low during reset
   always_comb begin
      phase2_s    = ~rst & p2_v_r[0];
      wb_now_s    = ~rst & wb_v_r[0];
      add_issue   = phase2_s | (accept_s & is_add_op_s);
      add_src_sel = phase2_s;
      add_sub     = accept_s & (req_op == OP_FSUB);
      mul_issue   = accept_s & is_mul_op_s;
      wb_valid    = wb_now_s;
      busy        = ~rst & (|pending_r);
      if (phase2_s) begin
         add_rs3 = p2_rs3_r[0];
      end else begin
         add_rs3 = 5'd0;
      end
      if (wb_now_s) begin
         wb_rd  = wb_rd_r[0];
         wb_sel = wb_sel_r[0];
      end else begin
         wb_rd  = 5'd0;
         wb_sel = 1'b0;
      end
   end

   // Reservation schedules advance one slot per cycle; new entries land one below
   // their distance because the shift happens on the same edge
   always_comb begin
      wb_v_n_s   = {1'b0, wb_v_r[WB_LEN-1:1]};
      wb_rd_n_s  = {5'd0, wb_rd_r[WB_LEN-1:1]};
      wb_sel_n_s = {1'b0, wb_sel_r[WB_LEN-1:1]};
      p2_v_n_s   = {1'b0, p2_v_r[P2_LEN-1:1]};
      p2_rs3_n_s = {5'd0, p2_rs3_r[P2_LEN-1:1]};
      if (accept_s) begin
         case (req_op)
            OP_FADD, OP_FSUB: begin
               wb_v_n_s[ADD_LAT-1]   = 1'b1;
               wb_rd_n_s[ADD_LAT-1]  = req_rd;
               wb_sel_n_s[ADD_LAT-1] = 1'b0;
            end
            OP_FMUL: begin
               wb_v_n_s[MUL_LAT-1]   = 1'b1;
               wb_rd_n_s[MUL_LAT-1]  = req_rd;
               wb_sel_n_s[MUL_LAT-1] = 1'b1;
            end
            OP_FMADD: begin
               wb_v_n_s[FMA_LAT-1]   = 1'b1;
               wb_rd_n_s[FMA_LAT-1]  = req_rd;
               wb_sel_n_s[FMA_LAT-1] = 1'b0;
               p2_v_n_s[MUL_LAT-1]   = 1'b1;
               p2_rs3_n_s[MUL_LAT-1] = req_rs3;
            end
            default: begin
               wb_v_n_s = {1'b0, wb_v_r[WB_LEN-1:1]};
            end
         endcase
      end else begin
         p2_v_n_s = {1'b0, p2_v_r[P2_LEN-1:1]};
      end
   end

   // Scoreboard: accept can never target the register being written back (WAW stall),
   // so set and clear always touch different bits
   always_comb begin
      if (wb_v_r[0]) begin
         clr_mask_s = 32'd1 << wb_rd_r[0];
      end else begin
         clr_mask_s = 32'd0;
      end
      if (accept_s) begin
         set_mask_s = 32'd1 << req_rd;
      end else begin
         set_mask_s = 32'd0;
      end
      pending_n_s = (pending_r & ~clr_mask_s) | set_mask_s;
   end

   // State registers; reset discards everything still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= 32'd0;
         wb_v_r    <= '0;
         wb_rd_r   <= '0;
         wb_sel_r  <= '0;
         p2_v_r    <= '0;
         p2_rs3_r  <= '0;
      end else begin
         pending_r <= pending_n_s;
         wb_v_r    <= wb_v_n_s;
         wb_rd_r   <= wb_rd_n_s;
         wb_sel_r  <= wb_sel_n_s;
         p2_v_r    <= p2_v_n_s;
         p2_rs3_r  <= p2_rs3_n_s;
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: default latencies plus a MUL_LAT=4/ADD_LAT=2 instance.
module tb_fpu_issue_ctrl;

   localparam logic [1:0] OP_FADD  = 2'd0;
   localparam logic [1:0] OP_FMUL  = 2'd1;
   localparam logic [1:0] OP_FMADD = 2'd2;
   localparam logic [1:0] OP_FSUB  = 2'd3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       req_valid, req_ready, add_issue, add_sub, add_src_sel, mul_issue, wb_valid, wb_sel, busy;
   logic [1:0] req_op;
   logic [4:0] req_rd, req_rs1, req_rs2, req_rs3, add_rs3, wb_rd;

   logic       u2_req_valid, u2_req_ready, u2_add_issue, u2_add_sub, u2_add_src_sel, u2_mul_issue;
   logic       u2_wb_valid, u2_wb_sel, u2_busy;
   logic [1:0] u2_req_op;
   logic [4:0] u2_req_rd, u2_req_rs1, u2_req_rs2, u2_req_rs3, u2_add_rs3, u2_wb_rd;

   int total = 0;
   int bad   = 0;

   fpu_issue_ctrl #(.ADD_LAT(3), .MUL_LAT(3)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
      .add_issue(add_issue), .add_sub(add_sub), .add_src_sel(add_src_sel), .add_rs3(add_rs3),
      .mul_issue(mul_issue), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel), .busy(busy)
   );

   fpu_issue_ctrl #(.ADD_LAT(2), .MUL_LAT(4)) dut2 (
      .clk(clk), .rst(rst), .req_valid(u2_req_valid), .req_ready(u2_req_ready), .req_op(u2_req_op),
      .req_rd(u2_req_rd), .req_rs1(u2_req_rs1), .req_rs2(u2_req_rs2), .req_rs3(u2_req_rs3),
      .add_issue(u2_add_issue), .add_sub(u2_add_sub), .add_src_sel(u2_add_src_sel), .add_rs3(u2_add_rs3),
      .mul_issue(u2_mul_issue), .wb_valid(u2_wb_valid), .wb_rd(u2_wb_rd), .wb_sel(u2_wb_sel), .busy(u2_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic req(input logic v, input logic [1:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3);
      req_valid = v; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_rs3 = rs3;
      #1;
   endtask

   task automatic req2(input logic v, input logic [1:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3);
      u2_req_valid = v; u2_req_op = op; u2_req_rd = rd; u2_req_rs1 = rs1; u2_req_rs2 = rs2; u2_req_rs3 = rs3;
      #1;
   endtask

   initial begin
      // reset behaviour
      rst = 1'b1;
      req2(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      req(1'b1, OP_FADD, 5'd3, 5'd1, 5'd2, 5'd0);
      cyc();
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_add_issue", {31'd0, add_issue}, 32'd0);
      chk("rst_mul_issue", {31'd0, mul_issue}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      cyc();
      chk("rst_ready2", {31'd0, req_ready}, 32'd0);

      // single FADD f3=f1+f2, then WAW against the writeback cycle, then FSUB
      cyc(); rst = 1'b0;
      req(1'b1, OP_FADD, 5'd3, 5'd1, 5'd2, 5'd0);
      chk("fadd_ready", {31'd0, req_ready}, 32'd1);
      chk("fadd_add_issue", {31'd0, add_issue}, 32'd1);
      chk("fadd_add_sub", {31'd0, add_sub}, 32'd0);
      chk("fadd_src_sel", {31'd0, add_src_sel}, 32'd0);
      chk("fadd_mul_issue", {31'd0, mul_issue}, 32'd0);
      chk("fadd_busy_t0", {31'd0, busy}, 32'd0);
      cyc(); req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("fadd_busy_t1", {31'd0, busy}, 32'd1);
      chk("fadd_wb_t1", {31'd0, wb_valid}, 32'd0);
      cyc();
      chk("fadd_busy_t2", {31'd0, busy}, 32'd1);
      cyc(); req(1'b1, OP_FADD, 5'd3, 5'd1, 5'd2, 5'd0);
      chk("fadd_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("fadd_wb_rd", {27'd0, wb_rd}, 32'd3);
      chk("fadd_wb_sel", {31'd0, wb_sel}, 32'd0);
      chk("fadd_busy_t3", {31'd0, busy}, 32'd1);
      chk("waw_wb_ready", {31'd0, req_ready}, 32'd0);
      chk("waw_wb_issue", {31'd0, add_issue}, 32'd0);
      cyc();
      chk("fadd_busy_t4", {31'd0, busy}, 32'd0);
      chk("waw_next_ready", {31'd0, req_ready}, 32'd1);
      chk("waw_next_issue", {31'd0, add_issue}, 32'd1);
      cyc(); req(1'b1, OP_FSUB, 5'd4, 5'd1, 5'd2, 5'd0);
      chk("fsub_ready", {31'd0, req_ready}, 32'd1);
      chk("fsub_add_sub", {31'd0, add_sub}, 32'd1);
      chk("fsub_add_issue", {31'd0, add_issue}, 32'd1);
      cyc(); req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc();
      chk("waw_wb_rd", {27'd0, wb_rd}, 32'd3);
      cyc();
      chk("fsub_wb_rd", {27'd0, wb_rd}, 32'd4);
      chk("fsub_wb_sel", {31'd0, wb_sel}, 32'd0);
      cyc();
      chk("fsub_idle", {31'd0, busy}, 32'd0);

      // RAW: FMUL f5, dependent FADD held valid
      req(1'b1, OP_FMUL, 5'd5, 5'd1, 5'd2, 5'd0);
      chk("raw_mul_ready", {31'd0, req_ready}, 32'd1);
      chk("raw_mul_issue", {31'd0, mul_issue}, 32'd1);
      chk("raw_mul_no_add", {31'd0, add_issue}, 32'd0);
      cyc(); req(1'b1, OP_FADD, 5'd6, 5'd5, 5'd2, 5'd0);
      chk("raw_stall_t1", {31'd0, req_ready}, 32'd0);
      chk("raw_noissue_t1", {31'd0, add_issue}, 32'd0);
      cyc();
      chk("raw_stall_t2", {31'd0, req_ready}, 32'd0);
      cyc();
      chk("raw_stall_t3", {31'd0, req_ready}, 32'd0);
      chk("raw_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("raw_wb_rd", {27'd0, wb_rd}, 32'd5);
      chk("raw_wb_sel", {31'd0, wb_sel}, 32'd1);
      cyc();
      chk("raw_accept_t4", {31'd0, req_ready}, 32'd1);
      chk("raw_issue_t4", {31'd0, add_issue}, 32'd1);
      cyc(); req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc();
      cyc();
      chk("raw_dep_wb_rd", {27'd0, wb_rd}, 32'd6);
      cyc();
      chk("raw_idle", {31'd0, busy}, 32'd0);

      // FMADD f7=f1*f2+f4 with an independent FADD colliding on the add port
      req(1'b1, OP_FMADD, 5'd7, 5'd1, 5'd2, 5'd4);
      chk("fma_ready", {31'd0, req_ready}, 32'd1);
      chk("fma_mul_issue", {31'd0, mul_issue}, 32'd1);
      chk("fma_no_add", {31'd0, add_issue}, 32'd0);
      cyc(); req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("fma_no_add_t1", {31'd0, add_issue}, 32'd0);
      cyc();
      cyc(); req(1'b1, OP_FADD, 5'd8, 5'd1, 5'd2, 5'd0);
      chk("fma_p2_stall", {31'd0, req_ready}, 32'd0);
      chk("fma_p2_issue", {31'd0, add_issue}, 32'd1);
      chk("fma_p2_src_sel", {31'd0, add_src_sel}, 32'd1);
      chk("fma_p2_rs3", {27'd0, add_rs3}, 32'd4);
      chk("fma_p2_sub", {31'd0, add_sub}, 32'd0);
      chk("fma_p2_no_mul", {31'd0, mul_issue}, 32'd0);
      cyc();
      chk("fma_fadd_ready", {31'd0, req_ready}, 32'd1);
      chk("fma_fadd_issue", {31'd0, add_issue}, 32'd1);
      chk("fma_fadd_src", {31'd0, add_src_sel}, 32'd0);
      cyc(); req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc();
      chk("fma_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("fma_wb_rd", {27'd0, wb_rd}, 32'd7);
      chk("fma_wb_sel", {31'd0, wb_sel}, 32'd0);
      cyc();
      chk("fma_fadd_wb_rd", {27'd0, wb_rd}, 32'd8);
      cyc();
      chk("fma_idle", {31'd0, busy}, 32'd0);

      // writeback port conflict on the MUL_LAT=4 / ADD_LAT=2 instance
      req2(1'b1, OP_FMUL, 5'd1, 5'd10, 5'd11, 5'd0);
      chk("u2_mul_ready", {31'd0, u2_req_ready}, 32'd1);
      chk("u2_mul_issue", {31'd0, u2_mul_issue}, 32'd1);
      cyc(); req2(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      cyc(); req2(1'b1, OP_FADD, 5'd2, 5'd12, 5'd13, 5'd0);
      chk("u2_wb_conflict", {31'd0, u2_req_ready}, 32'd0);
      chk("u2_conflict_noissue", {31'd0, u2_add_issue}, 32'd0);
      cyc();
      chk("u2_fadd_ready", {31'd0, u2_req_ready}, 32'd1);
      chk("u2_fadd_issue", {31'd0, u2_add_issue}, 32'd1);
      cyc(); req2(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("u2_wb1_valid", {31'd0, u2_wb_valid}, 32'd1);
      chk("u2_wb1_rd", {27'd0, u2_wb_rd}, 32'd1);
      chk("u2_wb1_sel", {31'd0, u2_wb_sel}, 32'd1);
      cyc();
      chk("u2_wb2_rd", {27'd0, u2_wb_rd}, 32'd2);
      chk("u2_wb2_sel", {31'd0, u2_wb_sel}, 32'd0);
      cyc();
      chk("u2_idle", {31'd0, u2_busy}, 32'd0);

      // reset while an FMADD is in flight
      req(1'b1, OP_FMADD, 5'd9, 5'd1, 5'd2, 5'd4);
      chk("mid_fma_ready", {31'd0, req_ready}, 32'd1);
      cyc(); req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("mid_busy_t1", {31'd0, busy}, 32'd1);
      cyc(); rst = 1'b1; req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      cyc(); rst = 1'b0; req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("mid_no_p2", {31'd0, add_issue}, 32'd0);
      chk("mid_busy_t3", {31'd0, busy}, 32'd0);
      chk("mid_ready_t3", {31'd0, req_ready}, 32'd1);
      for (int k = 4; k <= 6; k++) begin
         cyc();
         chk("mid_no_wb", {31'd0, wb_valid}, 32'd0);
         chk("mid_no_add", {31'd0, add_issue}, 32'd0);
      end

      // back-to-back independent FADDs to f1..f8
      for (int j = 0; j < 11; j++) begin
         if (j < 8) begin
            req(1'b1, OP_FADD, 5'(j + 1), 5'd20, 5'd21, 5'd0);
            chk("b2b_ready", {31'd0, req_ready}, 32'd1);
            chk("b2b_issue", {31'd0, add_issue}, 32'd1);
         end else begin
            req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
         end
         chk("b2b_wb_valid", {31'd0, wb_valid}, (j >= 3) ? 32'd1 : 32'd0);
         chk("b2b_wb_rd", {27'd0, wb_rd}, (j >= 3) ? 32'(j - 2) : 32'd0);
         cyc();
      end
      req(1'b0, OP_FADD, 5'd0, 5'd0, 5'd0, 5'd0);
      chk("b2b_idle", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
